// File: rtl/gpio_seq.sv
// Pattern sequencer: plays a table of 16-bit words into the GPIO port registers at a programmable step rate; the CPU always wins the GPIO bus.
// Optional sequence-done interrupt is built when GPIO_SEQ_IRQ_EN is defined; otherwise irq is tied low and CTRL bit2 is ignored.
module gpio_seq #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] AD,
  input  logic [7:0] DI,
  output logic [7:0] DO,
  input  logic       rw,
  input  logic       cs,
  input  logic       cpu_gpio_cs,
  input  logic [1:0] cpu_gpio_ad,
  input  logic [7:0] cpu_gpio_di,
  output logic [1:0] g_ad,
  output logic [7:0] g_di,
  output logic       g_rw,
  output logic       g_cs,
  output logic       irq
);

  typedef enum logic [1:0] {IDLE, WR_HI, WR_LO, WAIT} state_t;

  localparam logic [8:0] DEPTH_W = 9'(DEPTH);

  state_t          state_q;
  logic            run_q, loop_q, done_q, done_d, irqen;
  logic [15:0]     prescale_q, timer_q;
  logic [7:0]      len_q, hi_latch_q;
  logic [AW-1:0]   ptr_q, idx_q;
  logic [15:0]     pat_mem [DEPTH];
  logic [15:0]     seq_word, ptr_word;
  logic [8:0]      len_eff;
  logic            wr_en, ctrl_wr, status_wr, dlo_wr;
  logic            last, stop, seq_done;

  assign wr_en     = cs & ~rw;
  assign ctrl_wr   = wr_en && (AD == 3'd0);
  assign status_wr = wr_en && (AD == 3'd1);
  assign dlo_wr    = wr_en && (AD == 3'd7);

  assign seq_word = pat_mem[idx_q];
  assign ptr_word = pat_mem[ptr_q];

  always_comb begin
    len_eff = {1'b0, len_q};
    if (len_q == 8'd0)
      len_eff = 9'd1;
    else if ({1'b0, len_q} > DEPTH_W)
      len_eff = DEPTH_W;
  end

  assign last = (9'(idx_q) == (len_eff - 9'd1));
  // A CTRL write clearing RUN takes effect in the same cycle it is issued.
  assign stop = ~run_q | (ctrl_wr & ~DI[0]);
  assign seq_done = (state_q == WR_LO) && !cpu_gpio_cs && !stop && last && !loop_q;

  always_comb begin
    done_d = done_q;
    if (status_wr && DI[0])
      done_d = 1'b0;
    if (seq_done)
      done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (dlo_wr)
      pat_mem[ptr_q] <= {hi_latch_q, DI};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      run_q      <= 1'b0;
      loop_q     <= 1'b0;
      done_q     <= 1'b0;
      prescale_q <= 16'd0;
      timer_q    <= 16'd0;
      len_q      <= 8'd0;
      hi_latch_q <= 8'd0;
      ptr_q      <= '0;
      idx_q      <= '0;
    end else begin
      if (ctrl_wr) begin
        run_q  <= DI[0];
        loop_q <= DI[1];
      end
      if (seq_done)
        run_q <= 1'b0;
      done_q <= done_d;
      if (wr_en && AD == 3'd2) prescale_q[15:8] <= DI;
      if (wr_en && AD == 3'd3) prescale_q[7:0]  <= DI;
      if (wr_en && AD == 3'd4) len_q            <= DI;
      if (wr_en && AD == 3'd6) hi_latch_q       <= DI;
      if (wr_en && AD == 3'd5)
        ptr_q <= DI[AW-1:0];
      else if (dlo_wr)
        ptr_q <= ptr_q + 1'b1;

      case (state_q)
        IDLE: begin
          if (ctrl_wr && DI[0]) begin
            idx_q   <= '0;
            state_q <= WR_HI;
          end
        end
        WR_HI: begin
          if (stop)
            state_q <= IDLE;
          else if (!cpu_gpio_cs)
            state_q <= WR_LO;
        end
        WR_LO: begin
          if (!cpu_gpio_cs) begin
            if (stop || (last && !loop_q)) begin
              state_q <= IDLE;
            end else begin
              idx_q   <= last ? '0 : idx_q + 1'b1;
              timer_q <= prescale_q;
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (stop)
            state_q <= IDLE;
          else if (timer_q == 16'd0)
            state_q <= WR_HI;
          else
            timer_q <= timer_q - 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef GPIO_SEQ_IRQ_EN
  logic irqen_q, irq_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      irqen_q <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (ctrl_wr)
        irqen_q <= DI[2];
      irq_q <= done_d & (ctrl_wr ? DI[2] : irqen_q);
    end
  end
  assign irqen = irqen_q;
  assign irq   = irq_q;
`else
  assign irqen = 1'b0;
  assign irq   = 1'b0;
`endif

  always_comb begin
    case (AD)
      3'd0:    DO = {(state_q != IDLE), 4'b0000, irqen, loop_q, run_q};
      3'd1:    DO = {7'd0, done_q};
      3'd2:    DO = prescale_q[15:8];
      3'd3:    DO = prescale_q[7:0];
      3'd4:    DO = len_q;
      3'd5:    DO = 8'(ptr_q);
      3'd6:    DO = ptr_word[15:8];
      default: DO = ptr_word[7:0];
    endcase
  end

  // CPU first; the sequencer only drives during its write states.
  always_comb begin
    g_ad = 2'b00;
    g_di = 8'h00;
    g_rw = 1'b1;
    g_cs = 1'b0;
    if (cpu_gpio_cs) begin
      g_ad = cpu_gpio_ad;
      g_di = cpu_gpio_di;
      g_rw = rw;
      g_cs = 1'b1;
    end else if (state_q == WR_HI && !stop) begin
      g_ad = 2'b00;
      g_di = seq_word[15:8];
      g_rw = 1'b0;
      g_cs = 1'b1;
    end else if (state_q == WR_LO) begin
      g_ad = 2'b01;
      g_di = seq_word[7:0];
      g_rw = 1'b0;
      g_cs = 1'b1;
    end
  end

endmodule

// File: tb/tb_gpio_seq.sv
// Directed bench for gpio_seq: register access, one-shot and looped playback, CPU bus priority, LEN/PTR limits.
module tb_gpio_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] AD = 3'd0;
  logic [7:0] DI = 8'd0;
  logic [7:0] DO;
  logic       rw = 1'b1;
  logic       cs = 1'b0;
  logic       cpu_gpio_cs = 1'b0;
  logic [1:0] cpu_gpio_ad = 2'd0;
  logic [7:0] cpu_gpio_di = 8'd0;
  logic [1:0] g_ad;
  logic [7:0] g_di;
  logic       g_rw, g_cs, irq;

  gpio_seq #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .AD(AD), .DI(DI), .DO(DO), .rw(rw), .cs(cs),
    .cpu_gpio_cs(cpu_gpio_cs), .cpu_gpio_ad(cpu_gpio_ad), .cpu_gpio_di(cpu_gpio_di),
    .g_ad(g_ad), .g_di(g_di), .g_rw(g_rw), .g_cs(g_cs), .irq(irq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Bus log of every selected GPIO cycle: {rw, ad, di} and the cycle it occurred in.
  int         lc[$];
  logic [10:0] lv[$];
  int         irq_hits = 0;
  always @(negedge clk) begin
    if (g_cs === 1'b1) begin
      lc.push_back(cyc);
      lv.push_back({g_rw, g_ad, g_di});
    end
    if (irq !== 1'b0) irq_hits++;
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    AD = a; DI = d; cs = 1'b1; rw = 1'b0;
    step();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string tag);
    AD = a;
    #1;
    chk(tag, {24'd0, DO}, {24'd0, exp});
  endtask

  task automatic wait_idle(input string tag, input int budget);
    AD = 3'd0;
    #1;
    for (int i = 0; i < budget && DO[7] !== 1'b0; i++) step();
    chk(tag, {31'd0, DO[7]}, 32'd0);
  endtask

  task automatic clear_log();
    lc.delete();
    lv.delete();
  endtask

  function automatic logic [10:0] ent(input int i);
    return (i < lv.size()) ? lv[i] : 11'h7FF;
  endfunction

  function automatic int ecyc(input int i);
    return (i < lc.size()) ? lc[i] : -1000;
  endfunction

  logic [10:0] exp3 [8];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp3 = '{11'h012, 11'h134, 11'h0AB, 11'h1CD, 11'h012, 11'h134, 11'h0AB, 11'h1CD};

    // Reset state
    repeat (3) step();
    rst = 1'b0;
    step();
    rd(3'd0, 8'h00, "rst_ctrl");
    rd(3'd1, 8'h00, "rst_status");
    rd(3'd2, 8'h00, "rst_pre_hi");
    rd(3'd3, 8'h00, "rst_pre_lo");
    rd(3'd4, 8'h00, "rst_len");
    rd(3'd5, 8'h00, "rst_ptr");
    chk("rst_g_cs", {31'd0, g_cs}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);

    // Table load and readback
    wr(3'd5, 8'd0);
    wr(3'd6, 8'h12); wr(3'd7, 8'h34);
    wr(3'd6, 8'hAB); wr(3'd7, 8'hCD);
    rd(3'd5, 8'd2, "t2_ptr_inc");
    wr(3'd5, 8'd1);
    rd(3'd6, 8'hAB, "t2_rd_hi1");
    rd(3'd7, 8'hCD, "t2_rd_lo1");
    wr(3'd5, 8'd0);
    rd(3'd6, 8'h12, "t2_rd_hi0");
    rd(3'd7, 8'h34, "t2_rd_lo0");

    // One-shot, LEN=2, PRESCALE=4 -> 7-clock step period
    wr(3'd4, 8'd2);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h04);
    rd(3'd3, 8'h04, "t2_pre_lo");
    clear_log();
    wr(3'd0, 8'h01);
    wait_idle("t2_idle", 50);
    chk("t2_cnt", lv.size(), 32'd4);
    chk("t2_e0", ent(0), 11'h012);
    chk("t2_e1", ent(1), 11'h134);
    chk("t2_e2", ent(2), 11'h0AB);
    chk("t2_e3", ent(3), 11'h1CD);
    chk("t2_hi_lo_gap", ecyc(1) - ecyc(0), 32'd1);
    chk("t2_period", ecyc(2) - ecyc(0), 32'd7);
    rd(3'd1, 8'h01, "t2_done");
    rd(3'd0, 8'h00, "t2_ctrl");

    // Looped playback, then clear RUN while in WAIT
    wr(3'd1, 8'h01);
    rd(3'd1, 8'h00, "t3_done_clr");
    clear_log();
    wr(3'd0, 8'h03);
    repeat (23) step();
    rd(3'd0, 8'h83, "t3_busy_in_wait");
    wr(3'd0, 8'h02);
    rd(3'd0, 8'h02, "t3_stopped");
    repeat (10) step();
    chk("t3_cnt", lv.size(), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_e%0d", i), ent(i), exp3[i]);
    chk("t3_period2", ecyc(4) - ecyc(0), 32'd14);
    chk("t3_period3", ecyc(6) - ecyc(0), 32'd21);
    rd(3'd1, 8'h00, "t3_no_done");

    // CPU holds the GPIO bus for 3 cycles while the sequencer sits in WR_HI
    clear_log();
    wr(3'd0, 8'h01);
    cpu_gpio_cs = 1'b1; cpu_gpio_ad = 2'd2; cpu_gpio_di = 8'h5A; rw = 1'b0;
    #1;
    chk("t4_cpu_pass", {21'd0, g_rw, g_ad, g_di}, {21'd0, 11'h25A});
    chk("t4_cpu_cs", {31'd0, g_cs}, 32'd1);
    repeat (3) step();
    cpu_gpio_cs = 1'b0; rw = 1'b1;
    #1;
    chk("t4_seq_hi", {21'd0, g_rw, g_ad, g_di}, {21'd0, 11'h012});
    wait_idle("t4_idle", 50);
    chk("t4_cnt", lv.size(), 32'd7);
    chk("t4_e0", ent(0), 11'h25A);
    chk("t4_e2", ent(2), 11'h25A);
    chk("t4_e3", ent(3), 11'h012);
    chk("t4_e6", ent(6), 11'h1CD);
    chk("t4_stall", ecyc(3) - ecyc(0), 32'd3);
    chk("t4_period", ecyc(5) - ecyc(3), 32'd7);

    // LEN=0 behaves as one step
    wr(3'd1, 8'h01);
    wr(3'd4, 8'd0);
    clear_log();
    wr(3'd0, 8'h01);
    wait_idle("t5_idle0", 50);
    chk("t5_len0_cnt", lv.size(), 32'd2);
    chk("t5_len0_e0", ent(0), 11'h012);
    chk("t5_len0_e1", ent(1), 11'h134);
    rd(3'd1, 8'h01, "t5_len0_done");

    // LEN=200 clamps to DEPTH; PRESCALE=0 -> 3-clock period
    wr(3'd1, 8'h01);
    wr(3'd3, 8'h00);
    wr(3'd4, 8'd200);
    clear_log();
    wr(3'd0, 8'h01);
    wait_idle("t5_idle200", 300);
    chk("t5_len200_cnt", lv.size(), 32'd32);
    chk("t5_len200_e0", ent(0), 11'h012);
    chk("t5_len200_e3", ent(3), 11'h1CD);
    chk("t5_len200_span", ecyc(31) - ecyc(0), 32'd46);
    rd(3'd1, 8'h01, "t5_len200_done");

    // PTR keeps only the low AW bits
    wr(3'd5, 8'd20);
    rd(3'd5, 8'd4, "ptr_wrap");

    chk("irq_never", irq_hits, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_seq.md
Name: gpio_seq

Overview:
- Bus-mastering pattern sequencer for the 16-bit GPIO port register block.
- Plays a stored table of 16-bit output words into the GPIO output registers at a programmable step rate, one-shot or looped.
- Shares the GPIO register bus with the CPU; the CPU always has priority.
- Sits between the CPU bus decoder and the GPIO block, and has its own 8-register CPU window.

Parameters:
- DEPTH, 16: number of 16-bit pattern words; must be a power of 2, at most 256.
- AW, 4: log2(DEPTH); width of the pattern index and of PTR.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- AD  in  3  CPU register address
- DI  in  8  CPU write data
- DO  out  8  CPU read data (combinational from AD)
- rw  in  1  1 = read, 0 = write
- cs  in  1  sequencer register window select
- cpu_gpio_cs  in  1  CPU is accessing the GPIO window this cycle
- cpu_gpio_ad  in  2  CPU GPIO address
- cpu_gpio_di  in  8  CPU GPIO write data
- g_ad  out  2  GPIO block address
- g_di  out  8  GPIO block write data
- g_rw  out  1  GPIO block rw
- g_cs  out  1  GPIO block select
- irq  out  1  sequence-done interrupt (only with the optional feature)

Behaviour:
- Registers, write when cs && ~rw, at posedge:
  - 0 CTRL: bit0 RUN, bit1 LOOP, bit2 IRQEN. Reads return {BUSY, 4'b0, IRQEN, LOOP, RUN}; BUSY = (state != IDLE).
  - 1 STATUS: bit0 DONE, sticky. Writing 1 to bit0 clears it.
  - 2/3 PRESCALE hi/lo: 16 bits.
  - 4 LEN: 8 bits. 0 is treated as 1; values above DEPTH are treated as DEPTH.
  - 5 PTR: table address; only the low AW bits are stored.
  - 6 DATA hi: writes a hi latch. Reads return pattern[PTR][15:8].
  - 7 DATA lo: writing commits pattern[PTR] <= {hi_latch, DI} and sets PTR <= PTR+1 mod DEPTH. Reads return pattern[PTR][7:0].
- Reset: CTRL=0, DONE=0, PRESCALE=0, LEN=0, PTR=0, hi_latch=0, state=IDLE, idx=0, timer=0, g_cs=0, irq=0. Pattern RAM is not reset.
- GPIO bus mux, combinational:
  - cpu_gpio_cs=1: g_* = {cpu_gpio_ad, cpu_gpio_di, rw, 1}.
  - Else the sequencer drives g_* during WR_HI/WR_LO: g_ad = 00 or 01, g_di = the matching byte of pattern[idx], g_rw=0, g_cs=1.
  - Otherwise g_cs=0, g_rw=1.
- FSM states: IDLE, WR_HI, WR_LO, WAIT.
  - IDLE: a CPU write of CTRL with RUN=1 sets idx=0 and goes to WR_HI next cycle.
  - WR_HI: if cpu_gpio_cs=1, hold (stall, no sequencer bus cycle). Else issue the hi write and go to WR_LO.
  - WR_LO: same stall rule. Issue the lo write, then:
    - If idx == LEN_eff-1 and LOOP=0: set DONE, clear RUN, go to IDLE.
    - Else: idx <= (idx == LEN_eff-1) ? 0 : idx+1; timer <= PRESCALE; go to WAIT.
  - WAIT: when timer==0 go to WR_HI, else timer--.
- Timing: unstalled step period = PRESCALE+3 clocks, measured WR_HI to WR_HI.
- Clearing RUN mid-sequence:
  - In WR_HI or WAIT: go to IDLE next cycle, no bus cycle; DONE is not set.
  - In WR_LO: the lo write still completes (including any stall), then IDLE; DONE is not set.
- Writing RUN=1 while BUSY does not restart the sequence.
- Table writes while running take effect at the next read of that index.
- Simultaneous DONE set and CPU clear-DONE in the same cycle: set wins.

Optional Feature:
- GPIO_SEQ_IRQ_EN defined: irq = DONE & IRQEN, registered from state; the IRQEN bit is writable.
- GPIO_SEQ_IRQ_EN undefined: irq tied 0; CTRL bit2 ignored on write and reads 0.

Test Plan:
- Reset then read registers 0-5 -> all read 0; g_cs=0.
- Load via PTR=0 and DATA: table[0]=1234h, table[1]=ABCDh; set LEN=2, PRESCALE=4, CTRL=01h -> GPIO writes (00,12),(01,34), then (00,AB),(01,CD) 7 clocks later; DONE=1; CTRL reads 00h.
- Same table with LOOP: CTRL=03h -> the pattern repeats 12,34,AB,CD,12,... every 7 clocks; clearing RUN during WAIT -> BUSY=0 next cycle and no further g_cs.
- Hold cpu_gpio_cs=1 for 3 cycles while the sequencer is in WR_HI -> g_* pass the CPU access for those cycles; the sequencer hi write follows on the 4th cycle; the following WAIT is unaffected.
- LEN=0 and LEN=200 with DEPTH=16 -> 1 step and 16 steps respectively; a PTR write of 20 reads back 4.
- With GPIO_SEQ_IRQ_EN: IRQEN=1, one-shot completes -> irq=1; writing STATUS=01h -> irq=0 next cycle. Without the macro -> irq stays 0 throughout.
